// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Sequences box-draw commands from two requesters (for example game logic
//   and the UI overlay) into one DrawBox fill engine. It arbitrates
//   round-robin, latches one command, holds draw_en until the engine reports
//   finished, then holds a release gap until finished is low again. This
//   gap lets the engine restart cleanly.
//
//   Optional feature: define DRAW_TIMEOUT_EN to abort a draw that stays in
//   WAIT for TIMEOUT_CYCLES cycles. An abort sets the sticky timeout_err flag
//   and issues no done_pulse. When the macro is not defined, WAIT holds
//   indefinitely and timeout_err is tied low. The port list is the same in
//   both builds.
//
//   Handshake: a requester's command transfers on a rising edge where its
//   valid and ready are both high. ready is combinational. It is high only in
//   IDLE, only while rst is high, and only for the requester that wins
//   arbitration. Because of this, ready depends on valid and at most one
//   ready is high in any cycle.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-low reset
//   req_a_valid/cmd     requester A command offer (cmd = x0,y0,x1,y1,color)
//   req_a_ready         A's command accepted this cycle
//   req_b_valid/cmd     requester B command offer
//   req_b_ready         B's command accepted this cycle
//   eng_draw_en         to DrawBox draw_en
//   eng_x0/y0/x1/y1     latched coordinates to DrawBox
//   eng_color           latched colour to DrawBox
//   eng_finished        from DrawBox finished
//   busy                registered, high whenever state is not IDLE
//   done_pulse          one-cycle pulse when a box completes
//   grant_id            requester of the current/last command (0 = A, 1 = B)
//   timeout_err         sticky abort flag
module draw_scheduler #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CMD_W          = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a_valid,
  input  logic [CMD_W-1:0] req_a_cmd,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [CMD_W-1:0] req_b_cmd,
  output logic             req_b_ready,
  output logic             eng_draw_en,
  output logic [7:0]       eng_x0,
  output logic [7:0]       eng_y0,
  output logic [7:0]       eng_x1,
  output logic [7:0]       eng_y1,
  output logic [23:0]      eng_color,
  input  logic             eng_finished,
  output logic             busy,
  output logic             done_pulse,
  output logic             grant_id,
  output logic             timeout_err
);

  // The WAIT counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("draw_scheduler: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_draw_en;
  logic        w_draw_en_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_busy;
  logic        r_grant_id;
  logic [7:0]  r_x0, r_y0, r_x1, r_y1;
  logic [23:0] r_color;
  logic        w_pick_a;
  logic        w_pick_b;
  logic        w_xfer;
  logic [55:0] w_cmd;
  logic        w_to_hit;

  // Arbitration: a lone requester wins. When both are valid, the requester
  // that did not win last time wins (grant_id resets to 1, so A goes first).
  always_comb begin
    w_pick_a = 1'b0;
    w_pick_b = 1'b0;
    if (r_state == S_IDLE && rst) begin
      if (req_a_valid && req_b_valid) begin
        w_pick_a = r_grant_id;
        w_pick_b = ~r_grant_id;
      end else begin
        w_pick_a = req_a_valid;
        w_pick_b = req_b_valid;
      end
    end
  end

  assign req_a_ready = w_pick_a;
  assign req_b_ready = w_pick_b;
  assign w_xfer      = w_pick_a | w_pick_b;
  assign w_cmd       = w_pick_b ? req_b_cmd[55:0] : req_a_cmd[55:0];

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_draw_en_nxt = r_draw_en;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_draw_en_nxt = 1'b0;
        if (w_xfer) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_draw_en_nxt = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_finished) begin
          w_draw_en_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_RELEASE;
        end else if (w_to_hit) begin
          w_draw_en_nxt = 1'b0;
          w_state_nxt   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_draw_en_nxt = 1'b0;
        // Leave only after the engine has dropped finished. This stops a
        // stale finished from ending the next command early.
        if (!eng_finished) w_state_nxt = S_IDLE;
      end
      default: begin
        w_draw_en_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_draw_en  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_grant_id <= 1'b1;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_color    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_draw_en <= w_draw_en_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_xfer) begin
        r_grant_id <= w_pick_b;
        r_x0       <= w_cmd[55:48];
        r_y0       <= w_cmd[47:40];
        r_x1       <= w_cmd[39:32];
        r_y1       <= w_cmd[31:24];
        r_color    <= w_cmd[23:0];
      end
    end
  end

`ifdef DRAW_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout_err;

  // The counter is 0 in the first WAIT cycle. When it holds
  // TIMEOUT_CYCLES-1, the draw has spent TIMEOUT_CYCLES cycles in WAIT.
  assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_to_cnt <= '0;
      else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + 16'd1;
      if (r_state == S_WAIT && !eng_finished && w_to_hit) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign eng_draw_en = r_draw_en;
  assign eng_x0      = r_x0;
  assign eng_y0      = r_y0;
  assign eng_x1      = r_x1;
  assign eng_y1      = r_y1;
  assign eng_color   = r_color;
  assign busy        = r_busy;
  assign done_pulse  = r_done;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler. It contains a clock/reset block, driver
// tasks, a behavioural DrawBox engine model, and a scoreboard. The scoreboard
// queue holds the expected {grant_id, command} for each draw, in order. The
// monitor pops one entry each time eng_draw_en rises and compares it. Each
// scenario task does its own inline comparisons.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a_valid = 1'b0;
  logic [55:0] req_a_cmd = '0;
  logic        req_a_ready;
  logic        req_b_valid = 1'b0;
  logic [55:0] req_b_cmd = '0;
  logic        req_b_ready;
  logic        eng_draw_en;
  logic [7:0]  eng_x0, eng_y0, eng_x1, eng_y1;
  logic [23:0] eng_color;
  logic        eng_finished = 1'b0;
  logic        busy, done_pulse, grant_id, timeout_err;

  int checks = 0;
  int errors = 0;
  logic [56:0] exp_q[$];
  logic [56:0] mon_exp;
  int n_done  = 0;
  int n_rdy_a = 0;

  // Engine model controls.
  int fin_delay = 30;
  int hold_len  = 1;
  bit never_fin = 1'b0;

  always #5 clk = ~clk;

  draw_scheduler #(.TIMEOUT_CYCLES(100), .CMD_W(56)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_cmd(req_a_cmd), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_cmd(req_b_cmd), .req_b_ready(req_b_ready),
    .eng_draw_en(eng_draw_en), .eng_x0(eng_x0), .eng_y0(eng_y0),
    .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_color(eng_color),
    .eng_finished(eng_finished), .busy(busy), .done_pulse(done_pulse),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // DrawBox model. It raises finished fin_delay cycles after draw_en rises,
  // then drops it hold_len cycles after draw_en falls.
  initial begin
    int cnt;
    int hold;
    cnt = 0;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (eng_draw_en) begin
        hold = 0;
        if (!eng_finished) begin
          cnt++;
          if (!never_fin && cnt >= fin_delay) eng_finished = 1'b1;
        end
      end else begin
        cnt = 0;
        if (eng_finished) begin
          hold++;
          if (hold >= hold_len) begin
            eng_finished = 1'b0;
            hold = 0;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pop on each draw_en rise, plus the done_pulse width.
  initial begin
    logic prev_en;
    logic prev_done;
    prev_en = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (eng_draw_en === 1'b1 && !prev_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_draw: got %h required no draw",
                   {grant_id, eng_x0, eng_y0, eng_x1, eng_y1, eng_color});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({grant_id, eng_x0, eng_y0, eng_x1, eng_y1, eng_color} !== mon_exp) begin
            errors++;
            $display("FAIL sb_cmd: got %h required %h",
                     {grant_id, eng_x0, eng_y0, eng_x1, eng_y1, eng_color}, mon_exp);
          end
        end
      end
      if (done_pulse === 1'b1) begin
        n_done++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: got pulse for 2+ cycles required 1");
        end
      end
      prev_en = (eng_draw_en === 1'b1);
      prev_done = (done_pulse === 1'b1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req_a_ready === 1'b1) n_rdy_a++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Offer one command, push its expected grant, wait for the transfer.
  task automatic send(input bit sel, input logic [55:0] cmd, output bit ok);
    ok = 1'b0;
    exp_q.push_back({sel, cmd});
    if (sel) begin req_b_valid = 1'b1; req_b_cmd = cmd; end
    else     begin req_a_valid = 1'b1; req_a_cmd = cmd; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((sel ? req_b_ready : req_a_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (sel) req_b_valid = 1'b0;
    else     req_a_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_pulse === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    req_a_valid = 1'b1; req_a_cmd = 56'hAB_CD_EF_12_345678;
    req_b_valid = 1'b1; req_b_cmd = 56'h11_22_33_44_556677;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({eng_draw_en, busy, done_pulse, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got en/busy/done/to=%b required 0000",
               {eng_draw_en, busy, done_pulse, timeout_err});
    end
    checks++;
    if ({eng_x0, eng_y0, eng_x1, eng_y1, eng_color} !== 56'h0) begin
      errors++;
      $display("FAIL reset_eng: got %h required 0",
               {eng_x0, eng_y0, eng_x1, eng_y1, eng_color});
    end
    checks++;
    if (grant_id !== 1'b1) begin
      errors++; $display("FAIL reset_grant: got %b required 1", grant_id);
    end
    checks++;
    if ({req_a_ready, req_b_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b required 00", {req_a_ready, req_b_ready});
    end
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_command();
    logic [55:0] cmd;
    bit ok;
    int r0, d0;
    cmd = {8'd50, 8'd60, 8'd70, 8'd110, 24'hFFFFFF};
    r0 = n_rdy_a;
    d0 = n_done;
    send(1'b0, cmd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_xfer: got no ready required ready"); end
    checks++;
    if ({eng_draw_en, busy} !== 2'b01) begin
      errors++; $display("FAIL single_issue: got en/busy=%b required 01", {eng_draw_en, busy});
    end
    tick();
    checks++;
    if (eng_draw_en !== 1'b1) begin
      errors++; $display("FAIL single_en_latency: got %b required 1", eng_draw_en);
    end
    checks++;
    if ({eng_x0, eng_y0, eng_x1, eng_y1, eng_color} !== cmd) begin
      errors++;
      $display("FAIL single_eng: got %h required %h",
               {eng_x0, eng_y0, eng_x1, eng_y1, eng_color}, cmd);
    end
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got no done_pulse required one"); end
    wait_idle(20, ok);
    repeat (3) tick();
    checks++;
    if ({ok, busy, grant_id} !== 3'b100) begin
      errors++; $display("FAIL single_idle: got idle_ok/busy/grant=%b required 100", {ok, busy, grant_id});
    end
    checks++;
    if (n_rdy_a - r0 != 1) begin
      errors++; $display("FAIL single_ready_cycles: got %0d required 1", n_rdy_a - r0);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++; $display("FAIL single_done_count: got %0d required 1", n_done - d0);
    end
    checks++;
    if (eng_color !== 24'hFFFFFF) begin
      errors++; $display("FAIL single_retain: got %h required FFFFFF", eng_color);
    end
  endtask

  task automatic test_round_robin();
    logic [55:0] ca, cb;
    int seen;
    bit ok;
    ca = {8'd1, 8'd2, 8'd3, 8'd4, 24'h0000FF};
    cb = {8'd9, 8'd8, 8'd7, 8'd6, 24'hFF0000};
    apply_reset();
    tick();
    exp_q.push_back({1'b0, ca});
    exp_q.push_back({1'b1, cb});
    exp_q.push_back({1'b0, ca});
    exp_q.push_back({1'b1, cb});
    req_a_cmd = ca; req_b_cmd = cb;
    req_a_valid = 1'b1; req_b_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (done_pulse === 1'b1) seen++;
      if (seen == 4) break;
      tick();
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    checks++;
    if (seen != 4) begin errors++; $display("FAIL rr_boxes: got %0d required 4", seen); end
    wait_idle(20, ok);
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_pending: got %0d left required 0", exp_q.size());
    end
    checks++;
    if ({ok, grant_id, eng_color} !== {2'b11, 24'hFF0000}) begin
      errors++;
      $display("FAIL rr_last: got idle/grant/color=%b/%b/%h required 1/1/FF0000", ok, grant_id, eng_color);
    end
  endtask

  task automatic test_release_handshake();
    logic [55:0] c1, c2;
    bit ok, early;
    int rel;
    c1 = {8'd10, 8'd20, 8'd30, 8'd40, 24'h123456};
    c2 = {8'd11, 8'd21, 8'd31, 8'd41, 24'h654321};
    hold_len = 5;
    send(1'b0, c1, ok);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rel_done: got no done_pulse required one"); end
    exp_q.push_back({1'b0, c2});
    req_a_cmd = c2;
    req_a_valid = 1'b1;
    rel = 0;
    early = 1'b0;
    while (busy === 1'b1 && rel < 50) begin
      rel++;
      @(negedge clk);
      if (req_a_ready !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (rel != 5) begin errors++; $display("FAIL rel_cycles: got %0d required 5", rel); end
    checks++;
    if (early) begin errors++; $display("FAIL rel_early_ready: got ready in RELEASE required 0"); end
    hold_len = 1;
    @(negedge clk);
    checks++;
    if (req_a_ready !== 1'b1) begin
      errors++; $display("FAIL rel_ready_after: got %b required 1", req_a_ready);
    end
    @(posedge clk); #1;
    req_a_valid = 1'b0;
    wait_done(200, ok);
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rel_second: got busy required idle"); end
  endtask

  task automatic test_reset_mid_draw();
    logic [55:0] ca, cb;
    bit ok;
    ca = {8'd5, 8'd6, 8'd7, 8'd8, 24'hAAAAAA};
    cb = {8'd15, 8'd16, 8'd17, 8'd18, 24'h555555};
    send(1'b0, ca, ok);
    for (int i = 0; i < 10; i++) begin
      if (eng_draw_en === 1'b1) break;
      tick();
    end
    repeat (10) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({eng_draw_en, busy, grant_id, done_pulse} !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset: got en/busy/grant/done=%b required 0010",
               {eng_draw_en, busy, grant_id, done_pulse});
    end
    rst = 1'b1;
    exp_q.push_back({1'b1, cb});
    req_b_cmd = cb;
    req_b_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_a_ready, req_b_ready} !== 2'b01) begin
      errors++; $display("FAIL mid_b_first: got a/b ready=%b required 01", {req_a_ready, req_b_ready});
    end
    @(posedge clk); #1;
    req_b_valid = 1'b0;
    wait_done(200, ok);
    wait_idle(20, ok);
    checks++;
    if ({ok, grant_id} !== 2'b11) begin
      errors++; $display("FAIL mid_b_done: got idle/grant=%b required 11", {ok, grant_id});
    end
  endtask

  task automatic test_timeout();
    logic [55:0] ca, cb;
    bit ok;
    int d0;
    ca = {8'd100, 8'd101, 8'd102, 8'd103, 24'h0F0F0F};
    cb = {8'd200, 8'd201, 8'd202, 8'd203, 24'hF0F0F0};
    d0 = n_done;
    never_fin = 1'b1;
    send(1'b0, ca, ok);
    for (int i = 0; i < 10; i++) begin
      if (eng_draw_en === 1'b1) break;
      tick();
    end
`ifdef DRAW_TIMEOUT_EN
    begin
      int hi;
      hi = 0;
      while (eng_draw_en === 1'b1 && hi < 300) begin
        hi++;
        tick();
      end
      checks++;
      if (hi != 100) begin errors++; $display("FAIL to_wait_cycles: got %0d required 100", hi); end
      checks++;
      if (timeout_err !== 1'b1) begin
        errors++; $display("FAIL to_flag: got %b required 1", timeout_err);
      end
      never_fin = 1'b0;
      wait_idle(20, ok);
      repeat (3) tick();
      checks++;
      if (n_done != d0) begin
        errors++; $display("FAIL to_no_done: got %0d pulses required 0", n_done - d0);
      end
      send(1'b1, cb, ok);
      wait_done(200, ok);
      wait_idle(20, ok);
      repeat (3) tick();
      checks++;
      if ({timeout_err, ok} !== 2'b11) begin
        errors++; $display("FAIL to_sticky: got flag/idle=%b required 11", {timeout_err, ok});
      end
      checks++;
      if (n_done != d0 + 1) begin
        errors++; $display("FAIL to_after_done: got %0d pulses required 1", n_done - d0);
      end
    end
`else
    repeat (1000) tick();
    checks++;
    if ({eng_draw_en, busy, timeout_err} !== 3'b110) begin
      errors++;
      $display("FAIL hold_1000: got en/busy/to=%b required 110", {eng_draw_en, busy, timeout_err});
    end
    checks++;
    if (n_done != d0) begin
      errors++; $display("FAIL hold_no_done: got %0d pulses required 0", n_done - d0);
    end
    never_fin = 1'b0;
    apply_reset();
    tick();
    checks++;
    if ({eng_draw_en, busy} !== 2'b00) begin
      errors++; $display("FAIL hold_reset: got en/busy=%b required 00", {eng_draw_en, busy});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_command();
    test_round_robin();
    test_release_handshake();
    test_reset_mid_draw();
    test_timeout();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences box-draw commands from two independent requesters into the single DrawBox fill engine.
- Example requesters: game logic and the UI overlay.
- Arbitrates round-robin, latches one command, holds the engine's draw enable until it reports finished, then forces a release gap so the engine restarts cleanly.
- Sits between the requesters and the DrawBox engine's `draw_en`/`finished` handshake. The engine's framebuffer write outputs bypass this block.

Parameters:
- `TIMEOUT_CYCLES`, default 20000: max cycles in WAIT before abort. Used only with `DRAW_TIMEOUT_EN`.
- `CMD_W`, default 56: command width = x0[55:48], y0[47:40], x1[39:32], y1[31:24], color[23:0]. Fixed layout; the parameter exists for documentation only.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `req_a_valid`  in  1  requester A has a command
- `req_a_cmd`  in  56  requester A command
- `req_a_ready`  out  1  A's command accepted this cycle
- `req_b_valid`  in  1  requester B has a command
- `req_b_cmd`  in  56  requester B command
- `req_b_ready`  out  1  B's command accepted this cycle
- `eng_draw_en`  out  1  to DrawBox `draw_en`
- `eng_x0`, `eng_y0`, `eng_x1`, `eng_y1`  out  8 each  latched coordinates to DrawBox
- `eng_color`  out  24  latched colour to DrawBox
- `eng_finished`  in  1  from DrawBox `finished`
- `busy`  out  1  high in any state other than IDLE
- `done_pulse`  out  1  one-cycle pulse when a box completes
- `grant_id`  out  1  requester of current/last command: 0 = A, 1 = B
- `timeout_err`  out  1  sticky abort flag

Behaviour:
- Reset (`rst` = 0 at a rising edge) takes priority over everything and yields:
  - state = IDLE
  - `eng_draw_en`, `busy`, `done_pulse`, `timeout_err` = 0
  - `eng_*` coordinate/colour registers = 0
  - `grant_id` = 1, so A wins first
  - `req_*_ready` = 0
  - The timeout counter clears.
  - A reset mid-draw discards the command. `eng_draw_en` is low the cycle after reset is sampled.
- `req_a_ready` and `req_b_ready` are combinational:
  - Each is high only in IDLE with `rst` = 1, and only for the winning requester.
  - At most one ready is high per cycle.
  - A transfer occurs when `valid` & `ready` are both high.
- Arbitration in IDLE:
  - Only one requester valid: it wins.
  - Both valid: the requester not equal to `grant_id` wins (strict alternation).
  - Neither valid: stay in IDLE.
- On transfer: latch the command into the `eng_*` registers, update `grant_id`, go to ISSUE.
- States:
  - **IDLE**: as above.
  - **ISSUE** (1 cycle): set `eng_draw_en` = 1 (registered), go to WAIT. Latency is 2 rising edges from the transfer edge to `eng_draw_en` visible high.
  - **WAIT**: hold `eng_draw_en` = 1 and hold `eng_*` stable.
    - When `eng_finished` = 1 is sampled: `eng_draw_en` goes 0 and `done_pulse` is 1 for exactly the next cycle. Go to RELEASE.
  - **RELEASE**: `eng_draw_en` = 0. Wait until `eng_finished` = 0 is sampled, then go to IDLE. Minimum 1 cycle in RELEASE.
- `eng_finished` high while in IDLE or ISSUE is ignored.
- `busy` is registered and equals (state ≠ IDLE).
- `eng_*` retain the last command after completion.
- Back-to-back commands: minimum 4 cycles per box excluding the engine's own draw time.

Optional Feature:
- Macro: `DRAW_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` before `eng_finished`: drop `eng_draw_en`, set `timeout_err` = 1 (sticky until reset), go to RELEASE. No `done_pulse` is issued.
- Not defined: no counter. WAIT holds indefinitely and `timeout_err` is tied 0. The port list is unchanged.

Test Plan:
1. **Reset and single command.** Stimulus: hold `rst` = 0 for 3 cycles, then release; A valid with cmd x0=50, y0=60, x1=70, y1=110, color=FFFFFF; engine model asserts `finished` 30 cycles after `draw_en` rises and drops it 1 cycle after `draw_en` falls. Required response:
   - `req_a_ready` high for exactly 1 cycle.
   - `eng_draw_en` high 2 edges after the transfer.
   - `eng_x0`=50, `eng_y0`=60, `eng_x1`=70, `eng_y1`=110, `eng_color`=FFFFFF.
   - One `done_pulse`, `grant_id`=0, then back to IDLE with `busy`=0.
2. **Simultaneous requests.** Stimulus: A and B valid continuously with distinct colors 0000FF / FF0000. Required response: grants alternate A, B, A, B across 4 boxes; `eng_color` sequence 0000FF, FF0000, 0000FF, FF0000.
3. **Release handshake.** Stimulus: engine holds `finished` high for 5 cycles after `draw_en` drops. Required response: scheduler stays in RELEASE those 5 cycles; no new ready until `finished` = 0 is sampled.
4. **Reset mid-draw.** Stimulus: assert `rst` = 0 during WAIT. Required response: next cycle `eng_draw_en`=0, `busy`=0, `grant_id`=1; after release, a pending B request alone is granted first.
5. **Timeout (`DRAW_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100).** Stimulus: engine never asserts `finished`. Required response:
   - `eng_draw_en` drops after 100 WAIT cycles.
   - `timeout_err`=1 and stays 1 across a subsequent successful command.
   - No `done_pulse` for the aborted command.
   - Without the macro: `eng_draw_en` is still high at 1000 cycles.
